// File: rtl/sysid_arbiter_pkg.sv
// sysid_arbiter_pkg: shared states, slave word addresses and data width for the system-ID arbiter
package sysid_arbiter_pkg;
  localparam int DW = 32;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;
  typedef enum logic [1:0] {CHK_ID, CHK_TS, RUN} state_e;
endpackage

// File: rtl/sysid_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or above ptr_i (mod N)
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);
  // Scan farthest offset first so the closest requester to the pointer wins last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = PW'((int'(ptr_i) + k) % N);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sysid_arbiter.sv
// sysid_arbiter: self-checks the system-ID slave, then round-robin shares it among read masters
module sysid_arbiter
  import sysid_arbiter_pkg::*;
#(
  parameter int            NUM_MASTERS        = 2,
  parameter logic [DW-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [DW-1:0] EXPECTED_TIMESTAMP = 32'd1367779031
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] m_read,
  input  logic [NUM_MASTERS-1:0] m_address,
  output logic [NUM_MASTERS-1:0] m_waitrequest,
  output logic [NUM_MASTERS-1:0] m_readdatavalid,
  output logic [DW-1:0]          m_readdata,
  output logic                   s_address,
  input  logic [DW-1:0]          s_readdata,
  input  logic                   recheck,
  output logic                   sysid_ok,
  output logic                   sysid_bad
);
  localparam int PW = $clog2(NUM_MASTERS);
  state_e                 state_q, state_d;
  logic [PW-1:0]          rr_q, rr_d, idx;
  logic [NUM_MASTERS-1:0] gnt, rdv_q, rdv_d;
  logic [DW-1:0]          rdata_q, rdata_d, id_q, id_d;
  logic                   vld, ok_q, ok_d, bad_q, bad_d;
  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req_i (m_read),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (idx),
    .vld_o (vld)
  );
  // Stall is combinational so masters see all-ones the instant reset asserts.
  assign m_waitrequest   = (reset_n && state_q == RUN) ? ~gnt : '1;
  assign m_readdatavalid = rdv_q;
  assign m_readdata      = rdata_q;
  assign sysid_ok        = ok_q;
  assign sysid_bad       = bad_q;
  always_comb begin
    state_d   = state_q;
    s_address = ADDR_ID;
    rr_d      = rr_q;
    rdv_d     = '0;
    rdata_d   = rdata_q;
    id_d      = id_q;
    ok_d      = ok_q;
    bad_d     = bad_q;
    case (state_q)
      CHK_ID: begin
        id_d    = s_readdata;
        state_d = CHK_TS;
      end
      CHK_TS: begin
        s_address = ADDR_TS;
        ok_d      = (id_q == EXPECTED_ID) && (s_readdata == EXPECTED_TIMESTAMP);
        bad_d     = !ok_d;
        state_d   = RUN;
      end
      default: begin
        if (vld) begin
          s_address = m_address[idx];
          rdata_d   = s_readdata;
          rdv_d     = gnt;
          rr_d      = (idx == PW'(NUM_MASTERS - 1)) ? '0 : idx + 1'b1;
        end
        if (recheck) state_d = CHK_ID;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CHK_ID;
      rr_q    <= '0;
      rdv_q   <= '0;
      rdata_q <= '0;
      id_q    <= '0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
      id_q    <= id_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
    end
  end
endmodule

// File: tb/tb_sysid_arbiter.sv
// tb_sysid_arbiter: vector table, reset/outage sequences and random traffic against a reference model
module tb_sysid_arbiter;
  localparam int N = 2;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1367779031;
  logic clock = 1'b0, reset_n = 1'b0, recheck = 1'b0;
  logic [N-1:0] m_read = '0, m_address = '0, m_waitrequest, m_readdatavalid;
  logic [31:0] m_readdata, s_readdata, id_val = EXP_ID, ts_val = EXP_TS;
  logic s_address, sysid_ok, sysid_bad;
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  assign s_readdata = s_address ? ts_val : id_val;
  sysid_arbiter #(.NUM_MASTERS(N), .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS)) dut (
    .clock(clock), .reset_n(reset_n), .m_read(m_read), .m_address(m_address),
    .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
    .s_address(s_address), .s_readdata(s_readdata), .recheck(recheck),
    .sysid_ok(sysid_ok), .sysid_bad(sysid_bad)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: cycles of check outage left, sticky status, pointer, pending read result.
  int outage, ptr;
  logic [31:0] mid, mdata;
  logic mok, mbad;
  logic [N-1:0] mrdv;
  task automatic model_reset();
    outage = 2; ptr = 0; mid = 0; mdata = 0; mok = 0; mbad = 0; mrdv = '0;
  endtask
  task automatic model_cycle();
    int g;
    logic [N-1:0] ew;
    g = -1;
    ew = '1;
    #3;
    if (outage == 0)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_read[(ptr + k) % N]) g = (ptr + k) % N;
    if (g >= 0) ew[g] = 1'b0;
    chk("waitrequest", 32'(m_waitrequest), 32'(ew));
    chk("s_address", 32'(s_address), (outage == 1) ? 32'd1 : (g >= 0) ? 32'(m_address[g]) : 32'd0);
    chk("readdatavalid", 32'(m_readdatavalid), 32'(mrdv));
    if (mrdv != 0) chk("readdata", m_readdata, mdata);
    chk("sysid_ok", 32'(sysid_ok), 32'(mok));
    chk("sysid_bad", 32'(sysid_bad), 32'(mbad));
    @(posedge clock);
    mrdv = '0;
    if (outage == 2) begin
      mid = id_val;
      outage = 1;
    end else if (outage == 1) begin
      mok = (mid == EXP_ID) && (ts_val == EXP_TS);
      mbad = !mok;
      outage = 0;
    end else begin
      if (g >= 0) begin
        mdata = m_address[g] ? ts_val : id_val;
        mrdv[g] = 1'b1;
        ptr = (g + 1) % N;
      end
      if (recheck) outage = 2;
    end
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    m_read = '0; recheck = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask
  typedef struct {
    logic [N-1:0] rd, ad;
    logic         rc;
    logic [N-1:0] wt, rdv;
    logic [31:0]  data;
    logic         ok;
  } vec_t;
  vec_t tv[13];
  initial begin
    tv[0]  = '{2'b11, 2'b01, 1'b0, 2'b11, 2'b00, 32'd0,  1'b0};
    tv[1]  = '{2'b11, 2'b01, 1'b0, 2'b11, 2'b00, 32'd0,  1'b0};
    tv[2]  = '{2'b11, 2'b01, 1'b0, 2'b10, 2'b00, 32'd0,  1'b1};
    tv[3]  = '{2'b11, 2'b01, 1'b0, 2'b01, 2'b01, EXP_TS, 1'b1};
    tv[4]  = '{2'b11, 2'b01, 1'b0, 2'b10, 2'b10, 32'd0,  1'b1};
    tv[5]  = '{2'b10, 2'b10, 1'b0, 2'b01, 2'b01, EXP_TS, 1'b1};
    tv[6]  = '{2'b10, 2'b10, 1'b0, 2'b01, 2'b10, EXP_TS, 1'b1};
    tv[7]  = '{2'b00, 2'b00, 1'b0, 2'b11, 2'b10, EXP_TS, 1'b1};
    tv[8]  = '{2'b01, 2'b00, 1'b1, 2'b10, 2'b00, 32'd0,  1'b1};
    tv[9]  = '{2'b01, 2'b00, 1'b0, 2'b11, 2'b01, 32'd0,  1'b1};
    tv[10] = '{2'b01, 2'b00, 1'b0, 2'b11, 2'b00, 32'd0,  1'b1};
    tv[11] = '{2'b01, 2'b00, 1'b0, 2'b10, 2'b00, 32'd0,  1'b1};
    tv[12] = '{2'b00, 2'b00, 1'b0, 2'b11, 2'b01, 32'd0,  1'b1};
    #3;
    m_read = '1;
    #1;
    chk("reset_wait", 32'(m_waitrequest), 32'h3);
    chk("reset_rdv", 32'(m_readdatavalid), 32'h0);
    chk("reset_data", m_readdata, 32'h0);
    chk("reset_ok", 32'(sysid_ok), 32'h0);
    chk("reset_bad", 32'(sysid_bad), 32'h0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      m_read = tv[i].rd; m_address = tv[i].ad; recheck = tv[i].rc;
      #3;
      chk($sformatf("vec%0d_wait", i), 32'(m_waitrequest), 32'(tv[i].wt));
      chk($sformatf("vec%0d_rdv", i), 32'(m_readdatavalid), 32'(tv[i].rdv));
      if (tv[i].rdv != 0) chk($sformatf("vec%0d_data", i), m_readdata, tv[i].data);
      chk($sformatf("vec%0d_ok", i), 32'(sysid_ok), 32'(tv[i].ok));
      chk($sformatf("vec%0d_bad", i), 32'(sysid_bad), 32'(1'b0));
      @(posedge clock);
      #1;
    end
    // Wrong timestamp: flagged bad, masters still served.
    ts_val = EXP_TS - 32'd1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      m_read = N'($urandom); m_address = N'($urandom); recheck = 1'b0;
      model_cycle();
    end
    chk("bad_flag", 32'(sysid_bad), 32'h1);
    ts_val = EXP_TS;
    // Reset one cycle after a grant kills the pending valid.
    do_reset();
    m_read = '0;
    repeat (2) model_cycle();
    m_read = 2'b01; m_address = 2'b01;
    model_cycle();
    reset_n = 1'b0;
    #3;
    chk("midrst_rdv", 32'(m_readdatavalid), 32'h0);
    chk("midrst_wait", 32'(m_waitrequest), 32'h3);
    chk("midrst_data", m_readdata, 32'h0);
    chk("midrst_ok", 32'(sysid_ok), 32'h0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (4) model_cycle();
    // Random traffic with rechecks and a slave whose timestamp occasionally goes wrong.
    for (int i = 0; i < 400; i++) begin
      m_read = N'($urandom); m_address = N'($urandom);
      recheck = ($urandom_range(11) == 0);
      if ($urandom_range(24) == 0) ts_val = (ts_val == EXP_TS) ? EXP_TS ^ 32'h10 : EXP_TS;
      if ($urandom_range(49) == 0) id_val = (id_val == EXP_ID) ? 32'h5 : EXP_ID;
      model_cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sysid_arbiter.md
# sysid_arbiter

Shares the single-word system-ID Avalon slave (address 0 = ID, address 1 = build timestamp, purely combinational read) between NUM_MASTERS Avalon-MM read masters. After reset, and again on request, it runs a self-check read of both words against build-time parameters before granting any master. It sits between the masters and the system-ID slave, and provides a registered one-cycle read pipeline plus sticky ok/bad status for boot firmware and an LED.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- EXPECTED_ID, 32'd0, value required at slave address 0
- EXPECTED_TIMESTAMP, 32'd1367779031, value required at slave address 1

Ports:
- clock  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- m_read  in  NUM_MASTERS  per-master read request, held until granted
- m_address  in  NUM_MASTERS  per-master word address (1 bit each)
- m_waitrequest  out  NUM_MASTERS  per-master stall; 0 only in the grant cycle
- m_readdatavalid  out  NUM_MASTERS  one-cycle pulse to the master granted on the previous cycle
- m_readdata  out  32  shared registered read data; qualified by m_readdatavalid
- s_address  out  1  address to the system-ID slave
- s_readdata  in  32  slave read data, combinational from s_address
- recheck  in  1  single-cycle pulse; re-runs the self-check
- sysid_ok  out  1  last self-check matched both words
- sysid_bad  out  1  last self-check mismatched at least one word

## Operation
- States: CHK_ID, CHK_TS, RUN. Reset enters CHK_ID.
- CHK_ID: s_address=0. At the clock edge, capture s_readdata into id_q and go to CHK_TS.
- CHK_TS: s_address=1. At the clock edge:
  - compare id_q==EXPECTED_ID and s_readdata==EXPECTED_TIMESTAMP;
  - sysid_ok=match, sysid_bad=!match;
  - go to RUN.
- During CHK_ID and CHK_TS, all m_waitrequest=1 and no readdatavalid is issued.
- RUN:
  - The round-robin arbiter picks one master with m_read=1, searching from rr_ptr upward, mod NUM_MASTERS.
  - Grant cycle: the granted master sees m_waitrequest=0, and s_address=m_address[grant].
  - At the edge: m_readdata <= s_readdata, readdatavalid_q[grant] <= 1, rr_ptr <= (grant+1) mod NUM_MASTERS.
  - Non-granted requesters see waitrequest=1.
- No request in RUN: s_address=0, rr_ptr unchanged, no readdatavalid.
- recheck=1 in RUN: the current cycle's grant (if any) completes normally, then the next state is CHK_ID. sysid_ok/sysid_bad hold their old values until CHK_TS updates them.
- recheck in CHK_ID/CHK_TS is ignored.
- Requests are not latched: a master that drops m_read while stalled is simply not served.
- One read per cycle maximum. Back-to-back grants to different or the same master are allowed.

## Timing
- Reset values: state=CHK_ID, rr_ptr=0, m_readdata=0, m_readdatavalid=0, sysid_ok=0, sysid_bad=0, id_q=0.
- m_waitrequest is combinational and forced to all-ones while reset_n=0.
- Status valid on the 2nd rising edge after reset_n deasserts. The first grant is possible in the cycle after that edge.
- Read latency: readdatavalid and data arrive exactly 1 cycle after the grant cycle.
- Recheck outage: 2 cycles of all-stall following the cycle recheck is sampled.
- Reset mid-operation: pending readdatavalid and status are cleared immediately (asynchronous), and the sequence restarts at CHK_ID.
- All requesters active: with N=2, grants alternate 0,1,0,1. With N masters, each is granted at least once per N cycles.

## Structure
- Package sysid_arbiter_pkg holds:
  - state enum {CHK_ID, CHK_TS, RUN};
  - ADDR_ID=1'b0, ADDR_TS=1'b1;
  - data width constant 32.
- Sub-module rr_arbiter holds the parameterised round-robin grant logic: one-hot grant plus index from a request vector and pointer. It is combinational, and the pointer register is kept in the parent.
- The top holds the FSM, address mux, data/valid registers and status flags.

## Test plan
- Reset release, slave returns 0 / 1367779031 → sysid_ok=1, sysid_bad=0 at the 2nd edge; m_waitrequest all 1 until then.
- Slave returns timestamp 1367779030 → sysid_bad=1, sysid_ok=0; masters still served afterwards.
- Masters 0 and 1 both read (addr 1 and 0) continuously → grants alternate. Each readdatavalid pulse comes 1 cycle after that master's waitrequest=0, with data 1367779031 or 0 respectively.
- Single master 1 reading addr 1 every cycle → waitrequest=0 every cycle, and readdatavalid on every cycle after the first.
- recheck pulse while master 0 is granted → master 0 still receives its data. The next 2 cycles stall all masters, and status is re-evaluated.
- reset_n asserted one cycle after a grant → no readdatavalid pulse, outputs return to reset values, and the check sequence restarts.
